// File: rtl/dmem_ctrl.sv
// Data-memory responder for the MEM-stage port: fixed-latency load/store engine
// over a word-organised RAM with byte/halfword lane handling and error flagging.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  write_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_misalign
);

    localparam int          RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [ADDR_WIDTH+1:0] addr_reg;
    logic [31:0]           data_reg;
    logic [2:0]            type_reg;
    logic                  rd_reg, wr_reg;

    logic                  accept, access, is_load;
    logic                  type_bad, align_bad, err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic                  ram_we, ram_re;

    logic [31:0] ram [0:RAM_DEPTH-1];
    logic [31:0] rword_reg;
    logic [7:0]  rbyte [4];
    logic [31:0] load_val;
    logic [31:0] hold_reg;
    logic        ready_reg, mis_reg, load_done_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_addr[31:ADDR_WIDTH+2]};

    assign accept   = (state_reg == IDLE) && (mem_read || mem_write);
    assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign is_load  = rd_reg && !wr_reg;
    assign word_idx = addr_reg[ADDR_WIDTH+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The request is frozen from acceptance until the FSM is idle again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            data_reg <= '0;
            type_reg <= '0;
            rd_reg   <= 1'b0;
            wr_reg   <= 1'b0;
        end else if (accept) begin
            addr_reg <= mem_addr[ADDR_WIDTH+1:0];
            data_reg <= write_data;
            type_reg <= write_type;
            rd_reg   <= mem_read;
            wr_reg   <= mem_write;
        end
    end

    always_comb begin
        if (wr_reg) begin
            type_bad = (type_reg > 3'd2);
        end else begin
            type_bad = (type_reg == 3'd3) || (type_reg[2:1] == 2'b11);
        end
        align_bad = ((type_reg[1:0] == 2'b01) && addr_reg[0]) ||
                    ((type_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
        err = type_bad || align_bad;
    end

    always_comb begin
        case (type_reg[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_reg[1:0];
                wlane = {4{data_reg[7:0]}};
            end
            2'b01: begin
                be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wlane = {2{data_reg[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = data_reg;
            end
        endcase
    end

    // Rejected accesses never touch the RAM; reset forces IDLE so a pending store is dropped.
    assign ram_we = access && wr_reg && !err;
    assign ram_re = access && is_load && !err;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && be[i]) begin
                ram[word_idx][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
        if (ram_re) begin
            rword_reg <= ram[word_idx];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rword_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_val = 32'd0;
        if (!err) begin
            case (type_reg[1:0])
                2'b00:   load_val = {24'd0, rbyte[addr_reg[1:0]]};
                2'b01:   load_val = {16'd0, addr_reg[1] ? rword_reg[31:16] : rword_reg[15:0]};
                default: load_val = rword_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg     <= 1'b0;
            mis_reg       <= 1'b0;
            load_done_reg <= 1'b0;
            hold_reg      <= 32'd0;
        end else begin
            ready_reg     <= access;
            mis_reg       <= access && err;
            load_done_reg <= access && is_load;
            if (load_done_reg) begin
                hold_reg <= load_val;
            end
        end
    end

    // During DONE a completed load is shown directly; otherwise the last result holds.
    assign mem_read_data = load_done_reg ? load_val : hold_reg;
    assign mem_ready     = ready_reg;
    assign mem_misalign  = mis_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at LATENCY=2, one at LATENCY=1.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [2:0]  ty    [2];
    logic [31:0] ad    [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        mis   [2];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd[0]), .mem_write(wr[0]), .write_type(ty[0]),
        .mem_addr(ad[0]), .write_data(wd[0]),
        .mem_read_data(rdata[0]), .mem_ready(ready[0]), .mem_misalign(mis[0])
    );

    dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd[1]), .mem_write(wr[1]), .write_type(ty[1]),
        .mem_addr(ad[1]), .write_data(wd[1]),
        .mem_read_data(rdata[1]), .mem_ready(ready[1]), .mem_misalign(mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request mid-cycle, wait for the ready pulse, check it, then
    // confirm no further pulse follows. hold keeps the request up across DONE.
    task automatic do_req(input string tag, input int sel, input logic rd_v, input logic wr_v,
                          input logic [2:0] ty_v, input logic [31:0] a_v, input logic [31:0] d_v,
                          input logic hold, input logic [31:0] exp_data, input logic exp_mis);
        int k;
        int pulses;
        int exp_lat;
        exp_lat = (sel == 0) ? 3 : 2;
        @(negedge clk);
        rd[sel] = rd_v; wr[sel] = wr_v; ty[sel] = ty_v; ad[sel] = a_v; wd[sel] = d_v;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready[sel] && k < 20);
        check({tag, " lat"}, k, exp_lat);
        check({tag, " data"}, rdata[sel], exp_data);
        check({tag, " mis"}, {31'd0, mis[sel]}, {31'd0, exp_mis});
        $display("%-14s dut%0d rd=%0b wr=%0b type=%0d addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h mis=%0b",
                 tag, sel, rd_v, wr_v, ty_v, a_v, d_v, k, rdata[sel], mis[sel]);
        if (hold) @(negedge clk);
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready[sel]) pulses++;
            if (i == 0) check({tag, " mis after"}, {31'd0, mis[sel]}, 32'd0);
        end
        check({tag, " pulses"}, pulses, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; ty[s] = 3'd0; ad[s] = 32'd0; wd[s] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst rdata", rdata[0], 32'd0);
        check("rst ready", {31'd0, ready[0]}, 32'd0);
        check("rst mis", {31'd0, mis[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle ready", {31'd0, ready[0]}, 32'd0);

        // word round trip
        do_req("sw_10", 0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        do_req("lw_10", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // byte and half lanes
        do_req("sw_base", 0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req("sb_13", 0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h123456AA, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req("lw_lanes", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hAA223344, 1'b0);
        do_req("lbu_13", 0, 1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h000000AA, 1'b0);
        do_req("lhu_12", 0, 1'b1, 1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h0000AA22, 1'b0);
        do_req("lb_11", 0, 1'b1, 1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'h00000033, 1'b0);
        do_req("lh_10", 0, 1'b1, 1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'h00003344, 1'b0);
        do_req("sh_12", 0, 1'b0, 1'b1, 3'd1, 32'h12, 32'h9999BEEF, 1'b0, 32'h00003344, 1'b0);
        do_req("lw_sh", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);

        // misaligned and illegal
        do_req("sw_mis", 0, 1'b0, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 1'b0, 32'hBEEF3344, 1'b1);
        do_req("lw_after_mis", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);
        do_req("lh_mis", 0, 1'b1, 1'b0, 3'd1, 32'h11, 32'h0, 1'b0, 32'h00000000, 1'b1);
        do_req("st_type3", 0, 1'b0, 1'b1, 3'd3, 32'h10, 32'h0, 1'b0, 32'h00000000, 1'b1);
        do_req("lw_after_ill", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);
        do_req("ld_type7", 0, 1'b1, 1'b0, 3'd7, 32'h10, 32'h0, 1'b0, 32'h00000000, 1'b1);
        do_req("lw_restore", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);

        // both strobes, request held through DONE
        do_req("rdwr_20", 0, 1'b1, 1'b1, 3'd2, 32'h20, 32'h5, 1'b1, 32'hBEEF3344, 1'b0);
        do_req("lw_20", 0, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h00000005, 1'b0);

        // reset during BUSY discards the store
        do_req("sw_30_zero", 0, 1'b0, 1'b1, 3'd2, 32'h30, 32'h0, 1'b0, 32'h00000005, 1'b0);
        do_req("lw_prime", 0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; ty[0] = 3'd2; ad[0] = 32'h30; wd[0] = 32'h7;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst rdata", rdata[0], 32'd0);
        check("midrst ready", {31'd0, ready[0]}, 32'd0);
        check("midrst mis", {31'd0, mis[0]}, 32'd0);
        $display("reset_mid_busy dut0 addr=0x00000030 -> rdata=0x%08h ready=%0b mis=%0b",
                 rdata[0], ready[0], mis[0]);
        wr[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req("lw_30", 0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'h00000000, 1'b0);

        // address wrap on the LATENCY=1 instance
        do_req("l1_sw_1000", 1, 1'b0, 1'b1, 3'd2, 32'h1000, 32'h9, 1'b0, 32'h00000000, 1'b0);
        do_req("l1_lw_0", 1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h00000009, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
